// File: rtl/swo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// swo_pkg : SWO source mode constants and controller state encoding. Rev 1.0
// ---------------------------------------------------------------------------
package swo_pkg;

  localparam logic [1:0] SWO_MODE_OFF   = 2'd0;
  localparam logic [1:0] SWO_MODE_MANCH = 2'd1;
  localparam logic [1:0] SWO_MODE_UART  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } swo_state_e;

  // Reserved mode 3 behaves like off.
  function automatic logic swo_mode_runs(input logic [1:0] mode);
    return (mode == SWO_MODE_MANCH) || (mode == SWO_MODE_UART);
  endfunction

endpackage
`default_nettype wire

// File: rtl/swo_byte_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// swo_byte_fifo : synchronous byte FIFO, push/pop with full/empty. Rev 1.0
// ---------------------------------------------------------------------------
module swo_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       accepted,
  output logic       full,
  output logic       empty
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop frees the slot being written when full, so both proceed.
  assign accepted = push && (!full || do_pop) && !clr;
  assign dout     = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accepted) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/swo_source_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// swo_source_ctrl : selects Manchester/UART SWO decoder onto one byte stream.
// Optional statistics: define SWO_SOURCE_CTRL_STATS_EN.            Rev 1.0
// ---------------------------------------------------------------------------
module swo_source_ctrl
  import swo_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int RESET_CYCLES = 8,
  parameter int IDLE_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_mode,
  output logic        dec_rst,
  input  logic        manch_avail,
  input  logic [7:0]  manch_byte,
  input  logic        uart_avail,
  input  logic [7:0]  uart_byte,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [1:0]  active_mode,
  output logic [7:0]  overflow_cnt,
  output logic        idle
`ifdef SWO_SOURCE_CTRL_STATS_EN
  ,
  output logic [31:0] byte_cnt,
  output logic [7:0]  sync_loss_cnt
`endif
);

  swo_state_e  state, state_nxt;
  logic [1:0]  mode_q;
  logic [7:0]  flush_cnt;
  logic        manch_prev, uart_prev;
  logic [16:0] idle_cnt;
  logic        manch_ev, uart_ev, sel_ev;
  logic        push_req, fifo_clr, accepted, full, empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cfg_we) begin
      state_nxt = ST_FLUSH;
    end else if (state == ST_FLUSH && flush_cnt == 8'd0) begin
      state_nxt = swo_mode_runs(mode_q) ? ST_RUN : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= SWO_MODE_OFF;
      flush_cnt <= '0;
    end else if (cfg_we) begin
      mode_q    <= cfg_mode;
      flush_cnt <= 8'(RESET_CYCLES - 1);
    end else if (state == ST_FLUSH && flush_cnt != 8'd0) begin
      flush_cnt <= flush_cnt - 8'd1;
    end
  end

  // Toggle history tracks every cycle so stale strobes never count later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      manch_prev <= 1'b0;
      uart_prev  <= 1'b0;
    end else begin
      manch_prev <= manch_avail;
      uart_prev  <= uart_avail;
    end
  end

  assign manch_ev = manch_avail ^ manch_prev;
  assign uart_ev  = uart_avail ^ uart_prev;
  assign sel_ev   = (mode_q == SWO_MODE_MANCH) ? manch_ev :
                    (mode_q == SWO_MODE_UART)  ? uart_ev  : 1'b0;
  assign push_req = (state == ST_RUN) && !cfg_we && sel_ev;
  assign fifo_clr = (state != ST_RUN) || cfg_we;

  swo_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (fifo_clr),
    .push     (push_req),
    .din      ((mode_q == SWO_MODE_UART) ? uart_byte : manch_byte),
    .pop      (out_ready),
    .dout     (out_data),
    .accepted (accepted),
    .full     (full),
    .empty    (empty)
  );

  assign out_valid   = !empty;
  assign dec_rst     = (state != ST_RUN);
  assign active_mode = (state == ST_RUN) ? mode_q : SWO_MODE_OFF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_cnt <= '0;
    end else if (cfg_we) begin
      overflow_cnt <= '0;
    end else if (push_req && !accepted && full && overflow_cnt != 8'hFF) begin
      overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  // Saturates at the timeout so idle holds until the next event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (fifo_clr || push_req) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 17'(IDLE_TIMEOUT)) begin
      idle_cnt <= idle_cnt + 17'd1;
    end
  end

  assign idle = (idle_cnt == 17'(IDLE_TIMEOUT));

`ifdef SWO_SOURCE_CTRL_STATS_EN
  logic idle_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt      <= '0;
      sync_loss_cnt <= '0;
      idle_q        <= 1'b0;
    end else begin
      idle_q <= idle;
      if (cfg_we)        byte_cnt <= '0;
      else if (accepted) byte_cnt <= byte_cnt + 32'd1;
      if (idle && !idle_q && sync_loss_cnt != 8'hFF)
        sync_loss_cnt <= sync_loss_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_swo_source_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_swo_source_ctrl : directed self-checking bench for swo_source_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
module tb_swo_source_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic       dec_rst;
  logic       manch_avail = 1'b0;
  logic [7:0] manch_byte = 8'h00;
  logic       uart_avail = 1'b0;
  logic [7:0] uart_byte = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [1:0] active_mode;
  logic [7:0] overflow_cnt;
  logic       idle;
`ifdef SWO_SOURCE_CTRL_STATS_EN
  logic [31:0] byte_cnt;
  logic [7:0]  sync_loss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  swo_source_ctrl #(
    .FIFO_DEPTH  (4),
    .RESET_CYCLES(8),
    .IDLE_TIMEOUT(20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_mode    (cfg_mode),
    .dec_rst     (dec_rst),
    .manch_avail (manch_avail),
    .manch_byte  (manch_byte),
    .uart_avail  (uart_avail),
    .uart_byte   (uart_byte),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .active_mode (active_mode),
    .overflow_cnt(overflow_cnt),
    .idle        (idle)
`ifdef SWO_SOURCE_CTRL_STATS_EN
    ,
    .byte_cnt     (byte_cnt),
    .sync_loss_cnt(sync_loss_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [1:0] m);
    cfg_mode = m;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (dec_rst && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (dec_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_run: dec_rst=%b after %0d cycles, required 0", dec_rst, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({dec_rst, out_valid, out_data, active_mode, overflow_cnt, idle} !== {1'b1, 1'b0, 8'h00, 2'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got dec_rst=%b valid=%b data=%h mode=%0d ovf=%0d idle=%b, required 1 0 00 0 0 0",
               dec_rst, out_valid, out_data, active_mode, overflow_cnt, idle);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (dec_rst !== 1'b1 || active_mode !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: dec_rst=%b mode=%0d, required 1 0", dec_rst, active_mode);
    end
  endtask

  task automatic test_manch_basic();
    configure(2'd1);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (dec_rst !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_dec_rst[%0d]: dec_rst=%b, required 1", i, dec_rst);
      end
      tick();
    end
    n_checks++;
    if (dec_rst !== 1'b0 || active_mode !== 2'd1) begin
      n_fail++;
      $display("FAIL run_entry: dec_rst=%b mode=%0d, required 0 1", dec_rst, active_mode);
    end
    manch_byte  = 8'hA5;
    manch_avail = ~manch_avail;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL first_byte: valid=%b data=%h, required 1 a5", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_empty: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      manch_byte  = 8'(i);
      manch_avail = ~manch_avail;
      tick();
    end
    n_checks++;
    if (overflow_cnt !== 8'd2 || out_valid !== 1'b1 || out_data !== 8'h01) begin
      n_fail++;
      $display("FAIL overflow: ovf=%0d valid=%b data=%h, required 2 1 01", overflow_cnt, out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: valid=%b data=%h, required 1 %h", i, out_valid, out_data, 8'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_full_passthrough();
    for (int i = 0; i < 4; i++) begin
      manch_byte  = 8'h31 + 8'(i);
      manch_avail = ~manch_avail;
      tick();
    end
    manch_byte  = 8'h35;
    manch_avail = ~manch_avail;
    out_ready   = 1'b1;
    tick();
    out_ready   = 1'b0;
    n_checks++;
    if (overflow_cnt !== 8'd2 || out_data !== 8'h32) begin
      n_fail++;
      $display("FAIL full_push_pop: ovf=%0d data=%h, required 2 32", overflow_cnt, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h32 + 8'(i)) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: valid=%b data=%h, required 1 %h", i, out_valid, out_data, 8'h32 + 8'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_count: valid=%b after 4 pops, required 0", out_valid);
    end
  endtask

  task automatic test_uart_select();
    configure(2'd2);
    n_checks++;
    if (overflow_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL flush_clears_ovf: ovf=%0d, required 0", overflow_cnt);
    end
    uart_byte  = 8'h77;
    uart_avail = ~uart_avail;
    tick();
    wait_run();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b0 || active_mode !== 2'd2) begin
        n_fail++;
        $display("FAIL flush_strobe_ignored[%0d]: valid=%b mode=%0d, required 0 2", i, out_valid, active_mode);
      end
      tick();
    end
    manch_byte  = 8'h11;
    uart_byte   = 8'h22;
    manch_avail = ~manch_avail;
    uart_avail  = ~uart_avail;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      n_fail++;
      $display("FAIL uart_select: valid=%b data=%h, required 1 22", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL manch_ignored: valid=%b data=%h, required 0", out_valid, out_data);
    end
  endtask

  task automatic test_idle_and_async_reset();
    configure(2'd1);
    wait_run();
    for (int i = 0; i < 19; i++) tick();
    n_checks++;
    if (idle !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_early: idle=%b at 19 cycles, required 0", idle);
    end
    tick();
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_timeout: idle=%b at 20 cycles, required 1", idle);
    end
    tick();
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_hold: idle=%b at 21 cycles, required 1", idle);
    end
    manch_byte  = 8'h5A;
    manch_avail = ~manch_avail;
    tick();
    n_checks++;
    if (idle !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL idle_clear: idle=%b valid=%b data=%h, required 0 1 5a", idle, out_valid, out_data);
    end
`ifdef SWO_SOURCE_CTRL_STATS_EN
    n_checks++;
    if (byte_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL byte_cnt: got %0d, required 1", byte_cnt);
    end
`endif
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({dec_rst, out_valid, out_data, active_mode, overflow_cnt, idle} !== {1'b1, 1'b0, 8'h00, 2'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got dec_rst=%b valid=%b data=%h mode=%0d ovf=%0d idle=%b, required 1 0 00 0 0 0",
               dec_rst, out_valid, out_data, active_mode, overflow_cnt, idle);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_manch_basic();
    test_overflow();
    test_full_passthrough();
    test_uart_select();
    test_idle_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
